// File: rtl/mac_pkg.sv
// Shared types for the MAC result collector: FSM state encoding and sizing helpers.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        STALL = 2'd2
    } mac_state_e;

    // Counter width that stays legal for a single-sample frame.
    function automatic int cnt_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/defines.sv
// Global width defines shared by the MAC datapath blocks.
`ifndef MAC_DEFINES_SV
`define MAC_DEFINES_SV
`define DATA_WIDTH_OUT 16
`endif

// File: rtl/mac_result_fifo.sv
// Two-entry result FIFO holding packed {sum, ovf} frame results in arrival order.
module mac_result_fifo #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign count     = count_q;
    assign head_data = mem[rd_ptr];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the storage is reset too, because the head entry is visible on out_sum and must read 0 after reset.
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/mac_accum_collector.sv
// Sums FRAME_LEN MAC results per frame into a 2-entry result FIFO.
// Optional clamp-on-overflow behaviour is enabled by defining MAC_ACCUM_SATURATE_EN.
`ifndef DATA_WIDTH_OUT
`include "defines.sv"
`endif

module mac_accum_collector
    import mac_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int ACC_WIDTH = `DATA_WIDTH_OUT + 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [`DATA_WIDTH_OUT-1:0] in_data,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [ACC_WIDTH-1:0]       out_sum,
    output logic                       out_ovf,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int CNT_W = cnt_width(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef struct packed {
        logic [ACC_WIDTH-1:0] sum;
        logic                 ovf;
    } entry_t;

    logic [ACC_WIDTH-1:0] acc_q, acc_next, sum;
    logic [CNT_W-1:0]     cnt_q, cnt_next;
    logic                 sum_ovf;
    mac_state_e           state_q, state_next;
    logic                 accept, last, push, pop;
    logic                 fifo_full, fifo_empty;
    logic [1:0]           fifo_count, count_next;
    entry_t               push_entry, head_entry;

    assign accept    = in_valid && in_ready;
    assign last      = (cnt_q == CNT_LAST);
    assign push      = accept && last;
    assign pop       = out_valid && out_ready;
    assign in_ready  = !fifo_full && !flush;
    assign out_valid = !fifo_empty;
    assign out_sum   = head_entry.sum;
    assign out_ovf   = head_entry.ovf;
    assign busy      = (state_q != IDLE);

`ifdef MAC_ACCUM_SATURATE_EN
    logic                 ovf_q;
    logic [ACC_WIDTH:0]   sum_wide;

    assign sum_wide = {1'b0, acc_q} + (ACC_WIDTH + 1)'(in_data);
    assign sum_ovf  = ovf_q || sum_wide[ACC_WIDTH];
    assign sum      = sum_ovf ? '1 : sum_wide[ACC_WIDTH-1:0];

    // Sticky per-frame flag; the clamped accumulator alone cannot tell saturation from an exact all-ones sum.
    always_ff @(posedge clk) begin
        if (!rst_n || flush || push) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= sum_ovf;
        end
    end
`else
    assign sum_ovf = 1'b0;
    assign sum     = acc_q + ACC_WIDTH'(in_data);
`endif

    assign push_entry = '{sum: sum, ovf: sum_ovf};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch behind.
        acc_next   = acc_q;
        cnt_next   = cnt_q;
        state_next = IDLE;
        if (flush) begin
            acc_next = '0;
            cnt_next = '0;
        end else if (accept) begin
            if (last) begin
                acc_next = '0;
                cnt_next = '0;
            end else begin
                acc_next = sum;
                cnt_next = cnt_q + 1'b1;
            end
        end
        count_next = fifo_count + 2'(push) - 2'(pop);
        if (count_next == 2'd2) begin
            state_next = STALL;
        end else if (cnt_next != '0) begin
            state_next = ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values together.
            acc_q   <= acc_next;
            cnt_q   <= cnt_next;
            state_q <= state_next;
        end
    end

    mac_result_fifo #(
        .WIDTH($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mac_accum_collector.sv
// Directed bench for mac_accum_collector: default frame, 17-bit accumulator and single-sample frame instances.
module tb_mac_accum_collector;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance a: FRAME_LEN=4, ACC_WIDTH=20
    logic        a_in_valid, a_flush, a_out_ready;
    logic [15:0] a_in_data;
    logic        a_in_ready, a_out_valid, a_out_ovf, a_busy;
    logic [19:0] a_out_sum;

    // Instance b: FRAME_LEN=4, ACC_WIDTH=17
    logic        b_in_valid, b_flush, b_out_ready;
    logic [15:0] b_in_data;
    logic        b_in_ready, b_out_valid, b_out_ovf, b_busy;
    logic [16:0] b_out_sum;

    // Instance c: FRAME_LEN=1, ACC_WIDTH=20
    logic        c_in_valid, c_flush, c_out_ready;
    logic [15:0] c_in_data;
    logic        c_in_ready, c_out_valid, c_out_ovf, c_busy;
    logic [19:0] c_out_sum;

    int n_checks = 0;
    int n_fail   = 0;

    mac_accum_collector #(.FRAME_LEN(4), .ACC_WIDTH(20)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .flush(a_flush), .out_valid(a_out_valid),
        .out_sum(a_out_sum), .out_ovf(a_out_ovf), .out_ready(a_out_ready), .busy(a_busy)
    );

    mac_accum_collector #(.FRAME_LEN(4), .ACC_WIDTH(17)) u_w17 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .flush(b_flush), .out_valid(b_out_valid),
        .out_sum(b_out_sum), .out_ovf(b_out_ovf), .out_ready(b_out_ready), .busy(b_busy)
    );

    mac_accum_collector #(.FRAME_LEN(1), .ACC_WIDTH(20)) u_f1 (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_data(c_in_data),
        .in_ready(c_in_ready), .flush(c_flush), .out_valid(c_out_valid),
        .out_sum(c_out_sum), .out_ovf(c_out_ovf), .out_ready(c_out_ready), .busy(c_busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_flush = 1'b0; c_out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_sum",   32'(a_out_sum),   32'd0);
        check("rst_out_ovf",   32'(a_out_ovf),   32'd0);
        check("rst_busy",      32'(a_busy),      32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready",  32'(a_in_ready),  32'd1);

        // Frame 1,2,3,4 back-to-back, downstream ready
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data = 16'd1; tick();
        check("f1234_busy_mid", 32'(a_busy), 32'd1);
        a_in_data = 16'd2; tick();
        check("f1234_no_early_valid", 32'(a_out_valid), 32'd0);
        a_in_data = 16'd3; tick();
        a_in_data = 16'd4; tick();
        a_in_valid = 1'b0;
        check("f1234_out_valid", 32'(a_out_valid), 32'd1);
        check("f1234_out_sum",   32'(a_out_sum),   32'd10);
        check("f1234_busy_idle", 32'(a_busy),      32'd0);
        tick();
        check("f1234_valid_one_cycle", 32'(a_out_valid), 32'd0);

        // Backpressure: 12 samples of 1 with downstream stalled
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 16'd1;
        for (int i = 0; i < 8; i++) tick();
        check("bp_in_ready_full", 32'(a_in_ready), 32'd0);
        check("bp_busy_stall",    32'(a_busy),     32'd1);
        check("bp_head_sum",      32'(a_out_sum),  32'd4);
        tick();
        check("bp_ninth_held", 32'(a_in_ready), 32'd0);
        a_out_ready = 1'b1;
        tick();
        check("bp_second_valid", 32'(a_out_valid), 32'd1);
        check("bp_second_sum",   32'(a_out_sum),   32'd4);
        check("bp_in_ready_back", 32'(a_in_ready), 32'd1);
        tick();
        tick();
        tick();
        check("bp_third_pending", 32'(a_out_valid), 32'd0);
        tick();
        a_in_valid = 1'b0;
        check("bp_third_valid", 32'(a_out_valid), 32'd1);
        check("bp_third_sum",   32'(a_out_sum),   32'd4);
        tick();
        check("bp_drained", 32'(a_out_valid), 32'd0);

        // 17-bit accumulator, four samples of 0xFFFF
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 16'hFFFF;
        for (int i = 0; i < 4; i++) tick();
        b_in_valid = 1'b0;
        check("w17_out_valid", 32'(b_out_valid), 32'd1);
`ifdef MAC_ACCUM_SATURATE_EN
        check("w17_sum_sat",  32'(b_out_sum), 32'h1FFFF);
        check("w17_ovf_sat",  32'(b_out_ovf), 32'd1);
`else
        check("w17_sum_wrap", 32'(b_out_sum), 32'h1FFFC);
        check("w17_ovf_wrap", 32'(b_out_ovf), 32'd0);
`endif
        tick();

        // Flush mid-frame with a concurrent sample
        a_in_valid = 1'b1;
        a_in_data = 16'd5; tick();
        a_in_data = 16'd6; tick();
        a_flush   = 1'b1;
        a_in_data = 16'd100;
        #1;
        check("flush_in_ready_low", 32'(a_in_ready), 32'd0);
        tick();
        a_flush = 1'b0;
        check("flush_busy_idle", 32'(a_busy), 32'd0);
        a_in_data = 16'd1;
        for (int i = 0; i < 4; i++) tick();
        a_in_valid = 1'b0;
        check("flush_out_valid", 32'(a_out_valid), 32'd1);
        check("flush_out_sum",   32'(a_out_sum),   32'd4);
        tick();

        // Reset with one entry buffered and a partial frame
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 16'd3;
        for (int i = 0; i < 6; i++) tick();
        a_in_valid = 1'b0;
        check("prerst_out_valid", 32'(a_out_valid), 32'd1);
        check("prerst_busy",      32'(a_busy),      32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(a_out_valid), 32'd0);
        check("midrst_busy",      32'(a_busy),      32'd0);
        check("midrst_in_ready",  32'(a_in_ready),  32'd1);
        check("midrst_out_sum",   32'(a_out_sum),   32'd0);
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 16'd2;
        for (int i = 0; i < 4; i++) tick();
        a_in_valid = 1'b0;
        check("postrst_out_valid", 32'(a_out_valid), 32'd1);
        check("postrst_out_sum",   32'(a_out_sum),   32'd8);
        tick();

        // FRAME_LEN=1: each sample is its own frame
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        c_in_data = 16'd7; tick();
        check("f1_first_valid", 32'(c_out_valid), 32'd1);
        check("f1_first_sum",   32'(c_out_sum),   32'd7);
        check("f1_busy",        32'(c_busy),      32'd0);
        c_in_data = 16'd9; tick();
        c_in_valid = 1'b0;
        check("f1_second_valid", 32'(c_out_valid), 32'd1);
        check("f1_second_sum",   32'(c_out_sum),   32'd9);
        tick();
        check("f1_drained", 32'(c_out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
